// File: rtl/debug_prog_loader.sv
// UART-driven program loader and single-step/run debug controller for the pipeline.
// Define LOADER_CHECKSUM_EN to append an XOR checksum byte after each program load.
module debug_prog_loader #(
    parameter int unsigned MEM_DEPTH_WORDS = 256
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  rx_data,
    input  logic        rx_valid,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        DB_WE,
    input  logic [31:0] PC_in,
    input  logic        halt_in,
    output logic [7:0]  tx_data,
    output logic        tx_start,
    input  logic        tx_busy,
    output logic [2:0]  state_out
);

    localparam logic [2:0] IDLE     = 3'd0;
    localparam logic [2:0] LOAD     = 3'd1;
    localparam logic [2:0] WAIT_CMD = 3'd2;
    localparam logic [2:0] RUN      = 3'd3;
    localparam logic [2:0] STEP     = 3'd4;
    localparam logic [2:0] SEND_PC  = 3'd5;
    localparam logic [2:0] HALTED   = 3'd6;
`ifdef LOADER_CHECKSUM_EN
    localparam logic [2:0] SEND_CSUM = 3'd7;
`endif

    localparam logic [7:0]  CMD_LOAD = 8'h4C;
    localparam logic [7:0]  CMD_STEP = 8'h73;
    localparam logic [7:0]  CMD_RUN  = 8'h63;
    localparam logic [29:0] LAST_IDX = 30'(MEM_DEPTH_WORDS - 1);

    logic [2:0]  state;
    logic [2:0]  exit_state;
    logic [29:0] word_idx;
    logic [1:0]  byte_cnt;
    logic [31:0] load_word;
    logic [31:0] next_word;
    logic [31:0] tx_shift;
    logic [2:0]  tx_left;
    logic        need_sample;
    logic        start_load;
    logic        load_done;
    logic        take_byte;
`ifdef LOADER_CHECKSUM_EN
    logic [7:0]  csum;
`endif

    always_comb begin
        next_word  = {load_word[23:0], rx_data};
        start_load = rx_valid && (rx_data == CMD_LOAD) &&
                     (state == IDLE || state == WAIT_CMD || state == HALTED);
        // The write cycle decides the exit; a byte arriving then belongs to no word.
        load_done  = mem_we && (mem_wdata == 32'hFFFF_FFFF || word_idx == LAST_IDX);
        take_byte  = (state == LOAD) && rx_valid && !load_done;
    end

    assign DB_WE     = (state == STEP) || (state == RUN && !halt_in);
    assign state_out = state;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            exit_state  <= IDLE;
            word_idx    <= '0;
            byte_cnt    <= '0;
            load_word   <= '0;
            tx_shift    <= '0;
            tx_left     <= '0;
            need_sample <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            tx_data     <= '0;
            tx_start    <= 1'b0;
`ifdef LOADER_CHECKSUM_EN
            csum        <= '0;
`endif
        end else begin
            case (state)
                LOAD: begin
                    if (mem_we) begin
                        mem_we <= 1'b0;
                        if (load_done) begin
`ifdef LOADER_CHECKSUM_EN
                            state       <= SEND_CSUM;
                            tx_shift    <= {csum, 24'h0};
                            tx_left     <= 3'd1;
                            need_sample <= 1'b0;
                            exit_state  <= WAIT_CMD;
`else
                            state       <= WAIT_CMD;
`endif
                        end else begin
                            word_idx <= word_idx + 30'd1;
                        end
                    end
                    if (take_byte) begin
                        load_word <= next_word;
                        byte_cnt  <= byte_cnt + 2'd1;
`ifdef LOADER_CHECKSUM_EN
                        csum      <= csum ^ rx_data;
`endif
                        if (byte_cnt == 2'd3) begin
                            mem_we    <= 1'b1;
                            mem_wdata <= next_word;
                            mem_addr  <= {word_idx, 2'b00};
                        end
                    end
                end
                WAIT_CMD: begin
                    if (rx_valid && rx_data == CMD_STEP) begin
                        state <= STEP;
                    end else if (rx_valid && rx_data == CMD_RUN) begin
                        state <= RUN;
                    end
                end
                STEP: begin
                    state       <= SEND_PC;
                    need_sample <= 1'b1;
                    exit_state  <= halt_in ? HALTED : WAIT_CMD;
                end
                RUN: begin
                    if (halt_in) begin
                        state       <= SEND_PC;
                        need_sample <= 1'b1;
                        exit_state  <= HALTED;
                    end
                end
`ifdef LOADER_CHECKSUM_EN
                SEND_PC, SEND_CSUM: begin
`else
                SEND_PC: begin
`endif
                    // Busy is not trusted while tx_start is high; the UART has not seen it yet.
                    if (need_sample) begin
                        tx_shift    <= PC_in;
                        tx_left     <= 3'd4;
                        need_sample <= 1'b0;
                        if (halt_in) begin
                            exit_state <= HALTED;
                        end
                    end else if (tx_start) begin
                        tx_start <= 1'b0;
                        if (tx_left == 3'd0) begin
                            state <= exit_state;
                        end
                    end else if (!tx_busy) begin
                        tx_data  <= tx_shift[31:24];
                        tx_shift <= {tx_shift[23:0], 8'h00};
                        tx_start <= 1'b1;
                        tx_left  <= tx_left - 3'd1;
                    end
                end
                IDLE, HALTED: begin
                end
                default: begin
                    state <= IDLE;
                end
            endcase

            if (start_load) begin
                state     <= LOAD;
                word_idx  <= '0;
                byte_cnt  <= '0;
                load_word <= '0;
`ifdef LOADER_CHECKSUM_EN
                csum      <= '0;
`endif
            end
        end
    end

endmodule

// File: doc/debug_prog_loader.md
DEBUG_PROG_LOADER -- requirements
Module: debug_prog_loader

Interface
REQ-001 SHALL have parameter MEM_DEPTH_WORDS, default 256, instruction-memory capacity in 32-bit words.
REQ-002 SHALL have port clk  in  1  single clock, all state on rising edge.
REQ-003 SHALL have port reset  in  1  asynchronous, active-high reset.
REQ-004 SHALL have ports rx_data  in  8, received UART byte; rx_valid  in  1, one-cycle strobe marking rx_data valid.
REQ-005 SHALL have ports mem_we  out  1, instruction-memory write strobe; mem_addr  out  32, byte address; mem_wdata  out  32, write word.
REQ-006 SHALL have port DB_WE  out  1, pipeline advance enable (PC and IF/ID latch) driven to the fetch stage.
REQ-007 SHALL have port PC_in  in  32, current PC from the fetch stage; halt_in  in  1, pipeline reached halt instruction.
REQ-008 SHALL have ports tx_data  out  8, byte to UART TX; tx_start  out  1, one-cycle send strobe; tx_busy  in  1, TX occupied.
REQ-009 SHALL have port state_out  out  3, current FSM state encoding for debug.

Function
REQ-010 SHALL implement states IDLE, LOAD, WAIT_CMD, RUN, STEP, SEND_PC, HALTED.
REQ-011 IDLE: rx byte 0x4C ('L') -> LOAD with word address 0, byte counter 0; any other byte ignored.
REQ-012 LOAD: each rx_valid shifts rx_data into a 32-bit word, MSB first; on 4th byte mem_we=1 for exactly one cycle the following cycle, mem_wdata=assembled word, mem_addr=word_index*4.
REQ-013 LOAD: word_index increments after each write; written word 0xFFFFFFFF (halt marker) or write at index MEM_DEPTH_WORDS-1 -> WAIT_CMD; word_index never wraps.
REQ-014 WAIT_CMD: 0x73 ('s') -> STEP; 0x63 ('c') -> RUN; 0x4C -> LOAD (restart at address 0); others ignored.
REQ-015 STEP: DB_WE=1 for exactly one cycle, then SEND_PC; PC_in sampled on the cycle after that DB_WE pulse.
REQ-016 RUN: DB_WE=1 every cycle until halt_in=1; DB_WE drops the same cycle halt_in is seen; then SEND_PC; rx bytes ignored.
REQ-017 SEND_PC: sends sampled PC as 4 bytes MSB first; tx_start one-cycle pulse only when tx_busy=0; tx_busy ignored the cycle after tx_start; next byte waits for tx_busy=0.
REQ-018 SEND_PC exit: from STEP -> WAIT_CMD unless halt_in was 1 during the step -> HALTED; from RUN -> HALTED.
REQ-019 HALTED: DB_WE=0; only 0x4C accepted (-> LOAD); others ignored.
REQ-020 DB_WE SHALL be 0 in every state except as in REQ-015/016; mem_we 0 outside LOAD.
REQ-021 rx_valid and tx completion in the same cycle SHALL both be honoured where the state accepts them; rx bytes in SEND_PC are dropped.

Reset
REQ-022 reset=1 SHALL immediately force IDLE, DB_WE=0, mem_we=0, tx_start=0, mem_addr=0, mem_wdata=0, tx_data=0, counters=0, state_out=IDLE encoding.
REQ-023 Reset mid-LOAD SHALL discard the partial word with no memory write; reset mid-SEND_PC SHALL abort remaining bytes.

Configuration
REQ-024 With LOADER_CHECKSUM_EN defined, SHALL XOR all loaded bytes and, on leaving LOAD, send the 1-byte checksum (REQ-017 handshake) before entering WAIT_CMD.
REQ-025 Without LOADER_CHECKSUM_EN, LOAD SHALL go directly to WAIT_CMD and no checksum logic SHALL exist.

Verification
REQ-026 Load: bytes 4C,20,08,00,05,FF,FF,FF,FF -> writes 0x20080005@0x0, 0xFFFFFFFF@0x4; then WAIT_CMD, DB_WE=0 throughout.
REQ-027 Step: in WAIT_CMD send 73, PC_in=0x00000004 -> one DB_WE pulse, tx bytes 00,00,00,04, back to WAIT_CMD.
REQ-028 Run: send 63, assert halt_in after 10 cycles, PC_in=0x00000028 -> DB_WE high 10 cycles, tx 00,00,00,28, HALTED; byte 73 then ignored.
REQ-029 Overflow: MEM_DEPTH_WORDS=4, load 5 non-halt words -> exactly 4 writes (0x0-0xC), WAIT_CMD after 4th.
REQ-030 Reset after 2 bytes of a word in LOAD -> no mem_we, IDLE; with LOADER_CHECKSUM_EN, load 4C,01,02,03,04,FF,FF,FF,FF -> tx checksum 0x04.
